// File: rtl/proc_periph_pkg.sv
// proc_periph_pkg: shared handshake state encoding, source ids and default widths
package proc_periph_pkg;
  typedef enum logic [1:0] {IDLE, ACK_HI, DELIVER, DRAIN} hs_state_t;
  localparam logic SRC_P1 = 1'b0;
  localparam logic SRC_P2 = 1'b1;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/hs_timeout_counter.sv
// hs_timeout_counter: counts cycles a handshake ack is held and flags the abort limit
module hs_timeout_counter #(
  parameter int TMO_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TMO_CYC);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign expired = cnt == W'(TMO_CYC - 1);
endmodule

// File: rtl/periph_handshake_arbiter.sv
// periph_handshake_arbiter: round-robin four-phase capture of two peripherals onto one valid/ready path
module periph_handshake_arbiter
  import proc_periph_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TMO_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p1_req,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_ack,
  input  logic              p2_req,
  input  logic [DATA_W-1:0] p2_data,
  output logic              p2_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic              busy,
  output logic              err,
  output logic              err_src
);
  hs_state_t state, state_n;
  logic prio, prio_n, src_n, ack1_n, ack2_n, valid_n, err_n, err_src_n, clr, en, expired, gsel, greq;
  logic [DATA_W-1:0] data_n;
  hs_timeout_counter #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .expired(expired)
  );
  assign gsel = (p1_req & p2_req) ? prio : p2_req;
  assign greq = out_src ? p2_req : p1_req;
  always_comb begin
    state_n   = state;
    prio_n    = prio;
    data_n    = out_data;
    src_n     = out_src;
    ack1_n    = p1_ack;
    ack2_n    = p2_ack;
    valid_n   = out_valid;
    err_n     = 1'b0;
    err_src_n = err_src;
    clr       = 1'b0;
    en        = 1'b0;
    case (state)
      IDLE: begin
        clr = 1'b1;
        if (p1_req | p2_req) begin
          state_n = ACK_HI;
          data_n  = gsel ? p2_data : p1_data;
          src_n   = gsel;
          prio_n  = ~gsel;
          ack1_n  = ~gsel;
          ack2_n  = gsel;
        end
      end
      ACK_HI: begin
        if (!greq) begin
          ack1_n  = 1'b0;
          ack2_n  = 1'b0;
          valid_n = 1'b1;
          state_n = DELIVER;
        end else if (expired) begin
          ack1_n    = 1'b0;
          ack2_n    = 1'b0;
          err_n     = 1'b1;
          err_src_n = out_src;
          state_n   = DRAIN;
        end else en = 1'b1;
      end
      DELIVER: begin
        if (out_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      DRAIN: state_n = greq ? DRAIN : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      prio      <= SRC_P1;
      out_data  <= '0;
      out_src   <= SRC_P1;
      p1_ack    <= 1'b0;
      p2_ack    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      err_src   <= 1'b0;
    end else begin
      state     <= state_n;
      prio      <= prio_n;
      out_data  <= data_n;
      out_src   <= src_n;
      p1_ack    <= ack1_n;
      p2_ack    <= ack2_n;
      out_valid <= valid_n;
      busy      <= state_n != IDLE;
      err       <= err_n;
      err_src   <= err_src_n;
    end
endmodule

// File: tb/tb_periph_handshake_arbiter.sv
// tb_periph_handshake_arbiter: directed self-checking bench for the two-peripheral arbiter
module tb_periph_handshake_arbiter;
  logic clk = 1'b0;
  logic rst, p1_req, p2_req, p1_ack, p2_ack, out_valid, out_src, out_ready, busy, err, err_src;
  logic [7:0] p1_data, p2_data, out_data;
  int n_cmp = 0;
  int n_bad = 0;
  int got, c1, c2;
  logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
  logic       exp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  periph_handshake_arbiter #(.DATA_W(8), .TMO_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .p1_req(p1_req), .p1_data(p1_data), .p1_ack(p1_ack),
    .p2_req(p2_req), .p2_data(p2_data), .p2_ack(p2_ack),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
    .busy(busy), .err(err), .err_src(err_src)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; p1_req = 1'b1; p1_data = 8'h5A; p2_req = 1'b0; p2_data = 8'h00; out_ready = 1'b1;
    #50;
    chk("t1_rst_outs", {p1_ack, p2_ack, out_valid, busy, err, err_src, out_src}, 7'b0);
    chk("t1_rst_data", out_data, 8'h00);
    #50 rst = 1'b0;
    step();
    chk("t1_ack_lat", {p1_ack, p2_ack, busy}, 3'b101);
    p1_req = 1'b0;
    step();
    chk("t1_deliver", {p1_ack, out_valid, out_src, out_data}, {3'b010, 8'h5A});
    step();
    chk("t1_accept", {out_valid, busy}, 2'b00);
    p1_data = 8'hA5; p1_req = 1'b1;
    step();
    chk("t2_ack", {p1_ack, p2_ack, out_valid, busy, out_src, out_data}, {5'b10010, 8'hA5});
    p1_req = 1'b0;
    step();
    chk("t2_valid", {p1_ack, out_valid, out_src, out_data}, {3'b010, 8'hA5});
    step();
    chk("t2_accept", {out_valid, busy, out_data}, {2'b00, 8'hA5});
    rst = 1'b1;
    #3 rst = 1'b0;
    p1_data = 8'h11; p2_data = 8'h22; p1_req = 1'b1; p2_req = 1'b1; c1 = 1; c2 = 1; got = 0;
    for (int i = 0; i < 60 && got < 4; i++) begin
      step();
      chk("t3_excl", {31'd0, p1_ack & p2_ack}, 32'd0);
      if (out_valid) begin
        chk("t3_data", out_data, exp_d[got]);
        chk("t3_src", out_src, exp_s[got]);
        got++;
      end
      if (p1_req && p1_ack) p1_req = 1'b0;
      else if (!p1_req && !p1_ack && c1 < 2) begin p1_req = 1'b1; c1++; end
      if (p2_req && p2_ack) p2_req = 1'b0;
      else if (!p2_req && !p2_ack && c2 < 2) begin p2_req = 1'b1; c2++; end
    end
    chk("t3_count", got, 4);
    step();
    chk("t3_idle", {busy, out_valid}, 2'b00);
    p2_data = 8'h3C; p2_req = 1'b1;
    step();
    chk("t4_ack", {p2_ack, p1_ack}, 2'b10);
    p2_req = 1'b0; out_ready = 1'b0;
    step();
    chk("t4_valid", {out_valid, out_src, out_data}, {2'b11, 8'h3C});
    p1_data = 8'h77; p1_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t4_hold", {out_valid, out_src, p1_ack, p2_ack, out_data}, {4'b1100, 8'h3C});
    end
    out_ready = 1'b1;
    step();
    chk("t4_accept", {out_valid, p1_ack, busy}, 3'b000);
    step();
    chk("t4_p1_grant", {p1_ack, out_src, out_data}, {2'b10, 8'h77});
    p1_req = 1'b0;
    step();
    chk("t4_p1_valid", {out_valid, out_src, out_data}, {2'b10, 8'h77});
    step();
    chk("t4_p1_accept", out_valid, 1'b0);
    p1_data = 8'hE1; p1_req = 1'b1;
    step();
    chk("t5_ack", p1_ack, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t5_ack_hold", {p1_ack, err, out_valid}, 3'b100);
    end
    p2_data = 8'hC3; p2_req = 1'b1;
    step();
    chk("t5_abort", {p1_ack, p2_ack, err, err_src, out_valid, busy}, 6'b001001);
    step();
    chk("t5_err_pulse", {err, err_src, busy, p2_ack}, 4'b0010);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t5_drain", {p1_ack, p2_ack, out_valid, busy}, 4'b0001);
    end
    p1_req = 1'b0;
    step();
    chk("t5_drain_exit", {busy, p2_ack}, 2'b00);
    step();
    chk("t5_p2_grant", {p2_ack, out_src, out_data}, {2'b11, 8'hC3});
    p2_req = 1'b0;
    step();
    chk("t5_p2_valid", {out_valid, out_src, out_data, err_src}, {2'b11, 8'hC3, 1'b0});
    step();
    p2_data = 8'h99; p2_req = 1'b1;
    step();
    chk("t6_p2_ack", p2_ack, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_rst", {p2_ack, p1_ack, busy, out_valid, out_data}, 12'h000);
    #2 rst = 1'b0;
    p1_req = 1'b1;
    step();
    chk("t6_prio_p1", {p1_ack, p2_ack, out_src}, 3'b100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
